tdm_demux: RTL and testbench

//  Receiving end of the time-division multiplexed link built from our mux4to1/mux2to1 selectors.

---
 rtl/tdm_demux_pkg.sv | 12 +
 rtl/tdm_slot_counter.sv | 40 ++++
 rtl/tdm_demux.sv | 107 ++++++++++
 tb/tb_tdm_demux.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/tdm_demux_pkg.sv
// Shared definitions for the TDM link: FSM state encoding and default frame geometry.
package tdm_demux_pkg;

    localparam int unsigned DEFAULT_NUM_CH = 4;
    localparam int unsigned DEFAULT_W      = 1;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } tdm_state_e;

endpackage

// File: rtl/tdm_slot_counter.sv
// Mod-NUM_CH slot counter with synchronous clear / load-1 and terminal-count flag.
module tdm_slot_counter #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned SlotW  = $clog2(NUM_CH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear_i,
    input  logic             load1_i,
    input  logic             inc_i,
    output logic [SlotW-1:0] count_o,
    output logic             tc_o
);

    logic [SlotW-1:0] count_q, count_d;

    // Clear beats load-1 beats increment; wrap happens only through clear.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (load1_i) begin
            count_d = SlotW'(1);
        end else if (inc_i) begin
            count_d = count_q + SlotW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == SlotW'(NUM_CH - 1));

endmodule

// File: rtl/tdm_demux.sv
// TDM receiver: locks onto the frame marker, stages slots per channel and
// publishes each complete frame in parallel with a one-cycle valid pulse.
module tdm_demux
    import tdm_demux_pkg::*;
#(
    parameter int unsigned NUM_CH = DEFAULT_NUM_CH,
    parameter int unsigned W      = DEFAULT_W
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                sync,
    input  logic [W-1:0]        din,
    output logic [NUM_CH*W-1:0] dout,
    output logic                frame_valid,
    output logic                locked,
    output logic                sync_err
);

    localparam int unsigned SlotW = $clog2(NUM_CH);

    tdm_state_e               state_q, state_d;
    logic [NUM_CH-1:0][W-1:0] staging_q, staging_d;
    logic [NUM_CH*W-1:0]      dout_q, dout_d;
    logic                     fv_q, fv_d;
    logic                     err_q, err_d;

    logic [SlotW-1:0] slot;
    logic             slot_clr, slot_ld1, slot_inc, slot_tc;

    tdm_slot_counter #(
        .NUM_CH (NUM_CH),
        .SlotW  (SlotW)
    ) u_slot_counter (
        .clock   (clock),
        .reset_n (reset_n),
        .clear_i (slot_clr),
        .load1_i (slot_ld1),
        .inc_i   (slot_inc),
        .count_o (slot),
        .tc_o    (slot_tc)
    );

    always_comb begin
        state_d   = state_q;
        staging_d = staging_q;
        dout_d    = dout_q;
        fv_d      = 1'b0;
        err_d     = 1'b0;
        slot_clr  = 1'b0;
        slot_ld1  = 1'b0;
        slot_inc  = 1'b0;
        if (enable) begin
            unique case (state_q)
                ST_HUNT: begin
                    if (sync) begin
                        staging_d[0] = din;
                        slot_ld1     = 1'b1;
                        state_d      = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (sync) begin
                        // Early sync restarts the frame with this slot as slot 0.
                        err_d        = (slot != '0);
                        staging_d[0] = din;
                        slot_ld1     = 1'b1;
                    end else if (slot == '0) begin
                        err_d    = 1'b1;
                        state_d  = ST_HUNT;
                        slot_clr = 1'b1;
                    end else if (slot_tc) begin
                        dout_d   = {din, staging_q[NUM_CH-2:0]};
                        fv_d     = 1'b1;
                        slot_clr = 1'b1;
                    end else begin
                        staging_d[slot] = din;
                        slot_inc        = 1'b1;
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= ST_HUNT;
            staging_q <= '0;
            dout_q    <= '0;
            fv_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            staging_q <= staging_d;
            dout_q    <= dout_d;
            fv_q      <= fv_d;
            err_q     <= err_d;
        end
    end

    assign dout        = dout_q;
    assign frame_valid = fv_q;
    assign locked      = (state_q == ST_LOCKED);
    assign sync_err    = err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Directed vector bench for tdm_demux: 4x1 instance via a vector table, 8x4 instance by hand.
module tb_tdm_demux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 4-channel, 1-bit instance
    logic       rst_n_a = 1'b0, en_a = 1'b0, sy_a = 1'b0;
    logic [0:0] din_a = '0;
    logic [3:0] dout_a;
    logic       fv_a, lk_a, err_a;

    // 8-channel, 4-bit instance
    logic        rst_n_b = 1'b0, en_b = 1'b0, sy_b = 1'b0;
    logic [3:0]  din_b = '0;
    logic [31:0] dout_b;
    logic        fv_b, lk_b, err_b;

    tdm_demux #(.NUM_CH(4), .W(1)) u_dut_a (
        .clock       (clk),
        .reset_n     (rst_n_a),
        .enable      (en_a),
        .sync        (sy_a),
        .din         (din_a),
        .dout        (dout_a),
        .frame_valid (fv_a),
        .locked      (lk_a),
        .sync_err    (err_a)
    );

    tdm_demux #(.NUM_CH(8), .W(4)) u_dut_b (
        .clock       (clk),
        .reset_n     (rst_n_b),
        .enable      (en_b),
        .sync        (sy_b),
        .din         (din_b),
        .dout        (dout_b),
        .frame_valid (fv_b),
        .locked      (lk_b),
        .sync_err    (err_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       sy;
        logic       din;
        int         idle;   // enable-low cycles inserted before this vector
        logic [3:0] dout;
        logic       fv;
        logic       lk;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic e, input logic s, input logic d, input int idle,
                       input logic [3:0] o, input logic fv, input logic lk, input logic er);
        vec_t v;
        v.rst_n = r; v.en = e; v.sy = s; v.din = d; v.idle = idle;
        v.dout = o; v.fv = fv; v.lk = lk; v.err = er;
        vecs.push_back(v);
    endtask

    logic [3:0]  nib [8];
    logic [31:0] exp_b;

    initial begin
        // 1: reset held with enable/sync asserted
        add(0, 1, 1, 1, 0, 4'b0000, 0, 0, 0);
        add(0, 1, 1, 1, 0, 4'b0000, 0, 0, 0);
        // 2: contiguous frame 1,0,1,1
        add(1, 1, 1, 1, 0, 4'b0000, 0, 1, 0);
        add(1, 1, 0, 0, 0, 4'b0000, 0, 1, 0);
        add(1, 1, 0, 1, 0, 4'b0000, 0, 1, 0);
        add(1, 1, 0, 1, 0, 4'b1101, 1, 1, 0);
        add(1, 0, 0, 0, 0, 4'b1101, 0, 1, 0);
        // 3: frame 0,1,1,0 with 3-cycle gaps
        add(1, 1, 1, 0, 0, 4'b1101, 0, 1, 0);
        add(1, 1, 0, 1, 3, 4'b1101, 0, 1, 0);
        add(1, 1, 0, 1, 3, 4'b1101, 0, 1, 0);
        add(1, 1, 0, 0, 3, 4'b0110, 1, 1, 0);
        add(1, 0, 0, 0, 0, 4'b0110, 0, 1, 0);
        // 4: early sync on slot 2, then 0,0,1 completes the restarted frame
        add(1, 1, 1, 1, 0, 4'b0110, 0, 1, 0);
        add(1, 1, 0, 1, 0, 4'b0110, 0, 1, 0);
        add(1, 1, 1, 1, 0, 4'b0110, 0, 1, 1);
        add(1, 1, 0, 0, 0, 4'b0110, 0, 1, 0);
        add(1, 1, 0, 0, 0, 4'b0110, 0, 1, 0);
        add(1, 1, 0, 1, 0, 4'b1001, 1, 1, 0);
        // 5: slot 0 without sync drops lock; non-sync slots ignored until sync
        add(1, 1, 0, 1, 0, 4'b1001, 0, 0, 1);
        add(1, 1, 0, 1, 0, 4'b1001, 0, 0, 0);
        add(1, 1, 0, 0, 0, 4'b1001, 0, 0, 0);
        add(1, 1, 1, 0, 0, 4'b1001, 0, 1, 0);
        add(1, 1, 0, 1, 0, 4'b1001, 0, 1, 0);
        // 6: reset mid-frame, then a fresh frame 0,1,0,1
        add(0, 1, 1, 1, 0, 4'b0000, 0, 0, 0);
        add(1, 1, 1, 0, 0, 4'b0000, 0, 1, 0);
        add(1, 1, 0, 1, 0, 4'b0000, 0, 1, 0);
        add(1, 1, 0, 0, 0, 4'b0000, 0, 1, 0);
        add(1, 1, 0, 1, 0, 4'b1010, 1, 1, 0);
        // early sync on the last slot beats completion
        add(1, 1, 1, 1, 0, 4'b1010, 0, 1, 0);
        add(1, 1, 0, 1, 0, 4'b1010, 0, 1, 0);
        add(1, 1, 0, 1, 0, 4'b1010, 0, 1, 0);
        add(1, 1, 1, 0, 0, 4'b1010, 0, 1, 1);
        add(1, 1, 0, 1, 0, 4'b1010, 0, 1, 0);
        add(1, 1, 0, 1, 0, 4'b1010, 0, 1, 0);
        add(1, 1, 0, 1, 0, 4'b1110, 1, 1, 0);

        foreach (vecs[i]) begin
            for (int g = 0; g < vecs[i].idle; g++) begin
                @(negedge clk);
                en_a = 1'b0; sy_a = 1'b0;
                @(posedge clk); #1;
                chk($sformatf("v%0d gap fv", i), 32'(fv_a), 32'd0);
                chk($sformatf("v%0d gap err", i), 32'(err_a), 32'd0);
            end
            @(negedge clk);
            rst_n_a = vecs[i].rst_n; en_a = vecs[i].en; sy_a = vecs[i].sy; din_a = vecs[i].din;
            @(posedge clk); #1;
            chk($sformatf("v%0d dout", i), 32'(dout_a), 32'(vecs[i].dout));
            chk($sformatf("v%0d frame_valid", i), 32'(fv_a), 32'(vecs[i].fv));
            chk($sformatf("v%0d locked", i), 32'(lk_a), 32'(vecs[i].lk));
            chk($sformatf("v%0d sync_err", i), 32'(err_a), 32'(vecs[i].err));
        end

        // NUM_CH=8, W=4: reset state, then one full frame
        chk("b reset dout", dout_b, 32'd0);
        chk("b reset locked", 32'(lk_b), 32'd0);
        nib[0] = 4'hA; nib[1] = 4'h3; nib[2] = 4'hC; nib[3] = 4'h5;
        nib[4] = 4'h0; nib[5] = 4'hF; nib[6] = 4'h7; nib[7] = 4'h9;
        exp_b = 32'h97F0_5C3A;
        @(negedge clk);
        rst_n_b = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            en_b = 1'b1; sy_b = (k == 0); din_b = nib[k];
            @(posedge clk); #1;
            chk($sformatf("b slot%0d locked", k), 32'(lk_b), 32'd1);
            chk($sformatf("b slot%0d fv", k), 32'(fv_b), (k == 7) ? 32'd1 : 32'd0);
            chk($sformatf("b slot%0d err", k), 32'(err_b), 32'd0);
        end
        chk("b dout", dout_b, exp_b);
        @(negedge clk);
        en_b = 1'b0; sy_b = 1'b0;
        @(posedge clk); #1;
        chk("b fv drop", 32'(fv_b), 32'd0);
        chk("b dout hold", dout_b, exp_b);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
